// File: rtl/cmp2_share_arbiter_if.sv
// ----------------------------------------------------------------------------
// cmp2_share_arbiter_if
// Bundles the requester-side and response-side signals of the shared 2-bit
// equality comparator arbiter.
//
// Signals:
//   req        requester -> arbiter  per-requester request (N_REQ bits)
//   a_in       requester -> arbiter  operand A, requester i on [2i+1:2i]
//   b_in       requester -> arbiter  operand B, same packing as a_in
//   resp_ready consumer  -> arbiter  consumer accepts the current result
//   gnt        arbiter   -> requester one-hot grant, one cycle wide
//   busy       arbiter   -> all       arbiter is not idle
//   resp_valid arbiter   -> consumer  result available
//   resp_id    arbiter   -> consumer  requester index of the result
//   resp_eq    arbiter   -> consumer  1 when latched A equals latched B
//   cmp_count  arbiter   -> all       completed comparisons, saturating
//   eq_count   arbiter   -> all       completed equal comparisons, saturating
//
// Modports: master = requesters/consumer side, slave = the arbiter itself.
// ----------------------------------------------------------------------------
interface cmp2_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ),
    parameter int CNT_W = 8
);
    logic [N_REQ-1:0]   req;
    logic [2*N_REQ-1:0] a_in;
    logic [2*N_REQ-1:0] b_in;
    logic               resp_ready;
    logic [N_REQ-1:0]   gnt;
    logic               busy;
    logic               resp_valid;
    logic [ID_W-1:0]    resp_id;
    logic               resp_eq;
    logic [CNT_W-1:0]   cmp_count;
    logic [CNT_W-1:0]   eq_count;

    modport master (
        output req, a_in, b_in, resp_ready,
        input  gnt, busy, resp_valid, resp_id, resp_eq, cmp_count, eq_count
    );

    modport slave (
        input  req, a_in, b_in, resp_ready,
        output gnt, busy, resp_valid, resp_id, resp_eq, cmp_count, eq_count
    );
endinterface

// File: rtl/cmp2_share_arbiter.sv
// ----------------------------------------------------------------------------
// cmp2_share_arbiter
// Shares one 2-bit equality comparator between N_REQ requesters. A
// round-robin arbiter picks a winner, latches its operand pair, compares it
// in one pass and returns the result on a valid/ready channel tagged with
// the requester index. Saturating counters track completed comparisons and
// how many of them matched.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  cmp2_share_arbiter_if.slave (req/a_in/b_in/resp_ready in,
//        gnt/busy/resp_valid/resp_id/resp_eq/cmp_count/eq_count out)
// ----------------------------------------------------------------------------
module cmp2_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ),
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    cmp2_share_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        COMPARE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t           state_q;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  winner_q;
    logic [1:0]       op_a_q;
    logic [1:0]       op_b_q;
    logic [N_REQ-1:0] gnt_q;
    logic             resp_valid_q;
    logic [ID_W-1:0]  resp_id_q;
    logic             resp_eq_q;
    logic [CNT_W-1:0] cmp_count_q;
    logic [CNT_W-1:0] eq_count_q;

    logic [ID_W-1:0]  winner_d;
    logic [ID_W-1:0]  cand;
    logic             found;
    logic [1:0]       op_a_d;
    logic [1:0]       op_b_d;
    logic [ID_W-1:0]  rr_ptr_d;

    // Round-robin pick: first set request bit at or above rr_ptr, wrapping.
    always_comb begin
        winner_d = '0;
        cand     = '0;
        found    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr_q) + i) % N_REQ);
            if (!found && bus.req[cand]) begin
                found    = 1'b1;
                winner_d = cand;
            end
        end
    end

    // Operand slice of the winner, extracted with a constant-index mux.
    always_comb begin
        op_a_d = 2'b00;
        op_b_d = 2'b00;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == winner_d) begin
                op_a_d = bus.a_in[2*i +: 2];
                op_b_d = bus.b_in[2*i +: 2];
            end
        end
    end

    // Pointer moves just past the requester that was served.
    always_comb begin
        if (winner_q == ID_W'(N_REQ - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = winner_q + ID_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            winner_q     <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            gnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_eq_q    <= 1'b0;
            cmp_count_q  <= '0;
            eq_count_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        winner_q        <= winner_d;
                        op_a_q          <= op_a_d;
                        op_b_q          <= op_b_d;
                        gnt_q           <= '0;
                        gnt_q[winner_d] <= 1'b1;
                        state_q         <= GRANT;
                    end
                end
                GRANT: begin
                    gnt_q   <= '0;
                    state_q <= COMPARE;
                end
                COMPARE: begin
                    resp_eq_q    <= (op_a_q[1] ~^ op_b_q[1]) & (op_a_q[0] ~^ op_b_q[0]);
                    resp_id_q    <= winner_q;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    // Counters and pointer only advance on an accepted result.
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        rr_ptr_q     <= rr_ptr_d;
                        state_q      <= IDLE;
                        if (cmp_count_q != {CNT_W{1'b1}}) begin
                            cmp_count_q <= cmp_count_q + CNT_W'(1);
                        end
                        if (resp_eq_q && (eq_count_q != {CNT_W{1'b1}})) begin
                            eq_count_q <= eq_count_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_eq    = resp_eq_q;
    assign bus.cmp_count  = cmp_count_q;
    assign bus.eq_count   = eq_count_q;

endmodule

// File: tb/tb_cmp2_share_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cmp2_share_arbiter
// Self-checking bench for cmp2_share_arbiter. A transaction-level model of
// the arbiter predicts grant, busy, response and counter values every cycle;
// directed sequences add hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_cmp2_share_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;

    cmp2_share_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

    cmp2_share_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    // Model state: one transaction in flight at most; mAge counts cycles
    // since the request was accepted (1 = grant cycle, >=3 = result shown).
    bit   mIdle = 1'b1;
    int   mAge  = 0;
    int   mWin  = 0;
    int   mPtr  = 0;
    logic [1:0] mA = 2'b00;
    logic [1:0] mB = 2'b00;
    int   mCmp  = 0;
    int   mEq   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mIdle = 1'b1; mAge = 0; mWin = 0; mPtr = 0;
            mA = 2'b00; mB = 2'b00; mCmp = 0; mEq = 0;
        end else if (mIdle) begin
            if (bus.req != '0) begin
                for (int i = N_REQ - 1; i >= 0; i--) begin
                    if (bus.req[(mPtr + i) % N_REQ]) mWin = (mPtr + i) % N_REQ;
                end
                mA = bus.a_in[2*mWin +: 2];
                mB = bus.b_in[2*mWin +: 2];
                mIdle = 1'b0;
                mAge = 1;
            end
        end else if (mAge >= 3) begin
            if (bus.resp_ready) begin
                if (mCmp < CNT_MAX) mCmp++;
                if (mA == mB && mEq < CNT_MAX) mEq++;
                mPtr = (mWin + 1) % N_REQ;
                mIdle = 1'b1;
            end
        end else begin
            mAge++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, actual, expected, cycleCount);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            checkOutput("model_gnt", 32'(bus.gnt),
                        (!mIdle && mAge == 1) ? (32'd1 << mWin) : 32'd0);
            checkOutput("model_busy", 32'(bus.busy), 32'(!mIdle));
            checkOutput("model_valid", 32'(bus.resp_valid), 32'(!mIdle && mAge >= 3));
            checkOutput("model_cmp_count", 32'(bus.cmp_count), 32'(mCmp));
            checkOutput("model_eq_count", 32'(bus.eq_count), 32'(mEq));
            if (!mIdle && mAge >= 3) begin
                checkOutput("model_resp_id", 32'(bus.resp_id), 32'(mWin));
                checkOutput("model_resp_eq", 32'(bus.resp_eq), 32'(mA == mB));
            end
        end
    end

    task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic [2*N_REQ-1:0] a,
                                 input logic [2*N_REQ-1:0] b, input logic rdy);
        @(negedge clk);
        bus.req        = r;
        bus.a_in       = a;
        bus.b_in       = b;
        bus.resp_ready = rdy;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    int grantCycle[$];
    logic [N_REQ-1:0] grantVal[$];
    logic [N_REQ-1:0] expOrder [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        bus.req = '0; bus.a_in = '0; bus.b_in = '0; bus.resp_ready = 1'b0;

        // Reset values.
        #12;
        checkOutput("reset_gnt", 32'(bus.gnt), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("reset_cmp", 32'(bus.cmp_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single equal request from requester 0.
        applyStimulus(4'b0001, 8'b00_00_00_10, 8'b00_00_00_10, 1'b1);
        stepCycle();
        checkOutput("single_gnt", 32'(bus.gnt), 32'b0001);
        @(negedge clk); bus.req = '0;
        stepCycle();
        checkOutput("single_gnt_drop", 32'(bus.gnt), 32'd0);
        checkOutput("single_valid_early", 32'(bus.resp_valid), 32'd0);
        stepCycle();
        checkOutput("single_valid", 32'(bus.resp_valid), 32'd1);
        checkOutput("single_id", 32'(bus.resp_id), 32'd0);
        checkOutput("single_eq", 32'(bus.resp_eq), 32'd1);
        stepCycle();
        checkOutput("single_valid_done", 32'(bus.resp_valid), 32'd0);
        checkOutput("single_cmp", 32'(bus.cmp_count), 32'd1);
        checkOutput("single_eqcnt", 32'(bus.eq_count), 32'd1);

        // Mismatch on requester 2 with backpressure.
        applyStimulus(4'b0100, 8'b00_01_00_00, 8'b00_11_00_00, 1'b0);
        stepCycle();
        checkOutput("hold_gnt", 32'(bus.gnt), 32'b0100);
        @(negedge clk); bus.req = '0;
        stepCycle();
        stepCycle();
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_valid", 32'(bus.resp_valid), 32'd1);
            checkOutput("hold_id", 32'(bus.resp_id), 32'd2);
            checkOutput("hold_eq", 32'(bus.resp_eq), 32'd0);
            checkOutput("hold_cmp", 32'(bus.cmp_count), 32'd1);
            stepCycle();
        end
        @(negedge clk); bus.resp_ready = 1'b1;
        stepCycle();
        checkOutput("hold_valid_done", 32'(bus.resp_valid), 32'd0);
        checkOutput("hold_cmp_after", 32'(bus.cmp_count), 32'd2);
        checkOutput("hold_eqcnt_after", 32'(bus.eq_count), 32'd1);

        // Operand change during the grant cycle must not affect the result.
        applyStimulus(4'b0010, 8'b00_00_11_00, 8'b00_00_11_00, 1'b1);
        stepCycle();
        checkOutput("late_gnt", 32'(bus.gnt), 32'b0010);
        @(negedge clk); bus.req = '0; bus.a_in = '0;
        stepCycle();
        stepCycle();
        checkOutput("late_valid", 32'(bus.resp_valid), 32'd1);
        checkOutput("late_id", 32'(bus.resp_id), 32'd1);
        checkOutput("late_eq", 32'(bus.resp_eq), 32'd1);
        stepCycle();
        checkOutput("late_cmp", 32'(bus.cmp_count), 32'd3);
        checkOutput("late_eqcnt", 32'(bus.eq_count), 32'd2);

        // Reset asserted while a result is pending.
        applyStimulus(4'b1000, 8'b0, 8'b0, 1'b0);
        stepCycle();
        checkOutput("midrst_gnt", 32'(bus.gnt), 32'b1000);
        @(negedge clk); bus.req = '0;
        stepCycle();
        stepCycle();
        checkOutput("midrst_valid_before", 32'(bus.resp_valid), 32'd1);
        @(negedge clk); rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 32'(bus.resp_valid), 32'd0);
        checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrst_gnt0", 32'(bus.gnt), 32'd0);
        checkOutput("midrst_id", 32'(bus.resp_id), 32'd0);
        checkOutput("midrst_cmp", 32'(bus.cmp_count), 32'd0);
        checkOutput("midrst_eqcnt", 32'(bus.eq_count), 32'd0);
        @(negedge clk); rst = 1'b0; bus.resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("postrst_busy", 32'(bus.busy), 32'd0);
        end

        // Round robin with all requests held; requester 3 mismatches.
        applyStimulus(4'b1111, 8'b11_10_01_00, 8'b01_10_01_00, 1'b1);
        for (int i = 0; i < 40 && grantVal.size() < 5; i++) begin
            stepCycle();
            if (bus.gnt != '0) begin
                grantVal.push_back(bus.gnt);
                grantCycle.push_back(cycleCount);
            end
        end
        checkOutput("rr_grant_count", 32'(grantVal.size()), 32'd5);
        for (int i = 0; i < grantVal.size() && i < 5; i++) begin
            checkOutput("rr_order", 32'(grantVal[i]), 32'(expOrder[i]));
            if (i > 0) checkOutput("rr_spacing", 32'(grantCycle[i] - grantCycle[i-1]), 32'd4);
        end

        // Saturation: keep going with every requester's operands equal.
        @(negedge clk); bus.b_in = bus.a_in;
        repeat (270 * 4) @(posedge clk);
        @(negedge clk); bus.req = '0;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("sat_cmp", 32'(bus.cmp_count), 32'd255);
        checkOutput("sat_eqcnt", 32'(bus.eq_count), 32'd255);
        checkOutput("sat_idle", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp2_share_arbiter.md
Name: cmp2_share_arbiter

Overview:
- Shares one 2-bit equality comparator (A==B, per-bit XNOR then AND) between N_REQ requesters.
- Round-robin arbitration; winner's operand pair is latched and compared in one pass.
- Result returned on a valid/ready response channel tagged with the requester index.
- Sits between requesting units and the shared comparator datapath; keeps saturating usage/match statistics.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(N_REQ), width of the requester index.
- CNT_W, 8, width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester request; held high until own gnt bit is seen.
- a_in  in  2*N_REQ  operand A, requester i on bits [2i+1:2i].
- b_in  in  2*N_REQ  operand B, same packing.
- gnt  out  N_REQ  one-hot grant, high one cycle when operands are latched.
- busy  out  1  high in any state other than IDLE.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  ID_W  index of the requester the result belongs to.
- resp_eq  out  1  1 when latched A equals latched B.
- cmp_count  out  CNT_W  completed comparisons, saturating.
- eq_count  out  CNT_W  completed comparisons with resp_eq=1, saturating.

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt=0, busy=0, resp_valid=0, resp_id=0, resp_eq=0, rr_ptr=0, counters=0, operand regs=0. A transaction in flight is discarded with no response.
- States: IDLE, GRANT, COMPARE, RESP.
- IDLE, req==0: stay.
- IDLE, any req bit set: select the winner as the first set bit searching upward from rr_ptr, wrapping modulo N_REQ. Register the winner id and its a_in/b_in slice. Go to GRANT.
- GRANT: gnt[winner]=1 for exactly this cycle. Go to COMPARE.
  - Operands are already latched; changes on a_in/b_in or req during or after GRANT have no effect.
- COMPARE: resp_eq_reg <= (op_a[1]~^op_b[1]) & (op_a[0]~^op_b[0]); resp_id <= winner. Go to RESP.
- RESP: resp_valid=1. resp_id and resp_eq are stable until the handshake.
  - On resp_valid & resp_ready: cmp_count += 1, and eq_count += 1 if resp_eq=1; each counter saturates at 2^CNT_W-1.
  - Same edge: rr_ptr <= (winner+1) mod N_REQ; state goes to IDLE.
  - Otherwise stay in RESP (backpressure, no timeout).
- Latency, request to grant: request sampled at IDLE edge k, gnt high in cycle k+1, resp_valid first high in cycle k+3.
- Minimum spacing: back-to-back transactions are 4 cycles apart (RESP→IDLE→GRANT…) when resp_ready is held high.
- Requester rule: a requester that keeps req high after its gnt is treated as a new request and is serviced again per round-robin.
- Fairness: with all req high continuously, grant order is 0,1,2,…,N_REQ-1,0,…
- Req bits at index ≥ N_REQ do not exist. Only index values < N_REQ are ever produced; rr_ptr wraps from N_REQ-1 to 0.
- gnt, resp_valid and busy are registered or derived only from state, with no combinational path from inputs.

Test Plan:
- Reset: assert rst mid-RESP with resp_valid=1 → all outputs 0 immediately (before next clk edge); after release, req=0 keeps busy=0.
- Single request: req=0001, a_in[1:0]=2'b10, b_in[1:0]=2'b10, resp_ready=1 → gnt=0001 at k+1, resp_valid at k+3 with resp_id=0, resp_eq=1; cmp_count=1, eq_count=1.
- Mismatch and hold: req=0100, A=2'b01, B=2'b11, resp_ready=0 for 5 cycles → resp_valid held, resp_id=2, resp_eq=0; counters unchanged until ready, then cmp_count+1, eq_count unchanged.
- Round robin: req=1111 held, ready=1 → gnt sequence 0001,0010,0100,1000,0001, each 4 cycles apart.
- Late operand change: change a_in of the winner in the GRANT cycle → resp_eq reflects the value latched in IDLE.
- Saturation: CNT_W=8, 260 equal compares → cmp_count=eq_count=255.
